patch_encoder_writer: RTL and testbench
=======================================

// Module: patch_encoder_writer
// PURPOSE
//  Write-side companion of the flip/patch read path. Takes blocks of M activations plus the
//  per-lane stuck-at fault map of the target memory row. Decides per lane: store as-is, store
//  inverted (f=1), or patch (p=1). Streams each patched activation into the patch cache over
//  the cache request/store port, then presents the f/p vectors and the stored words.
// PARAMETERS
//  N       16  activation width (bits)
//  M       4   lanes per block
//  ADDR_W  21  patch-cache address width
// PORTS
//  clk            in   1        clock
//  reset          in   1        synchronous, active-high reset
//  in_valid       in   1        block offered on act_in/sa_mask/sa_val
//  in_ready       out  1        block accepted when in_valid & in_ready
//  act_in         in   N x M    original activations
//  sa_mask        in   N x M    1 = faulty (stuck) bit cell, per lane
//  sa_val         in   N x M    stuck value of each faulty cell
//  request        out  1        cache access request
//  read_write     out  1        always 0 (write)
//  address        out  ADDR_W   {blk_idx, lane}, zero-extended
//  activation_in  out  N        patch word = original activation
//  index          out  clog2(M) lane being written
//  store_enable   out  1        write strobe; held until cache_ready
//  cache_ready    in   1        cache accepts the write this cycle
//  f              out  1 x M    flip bits of completed block
//  p              out  1 x M    patch bits of completed block
//  stored_data    out  N x M    words to be written to faulty memory (act or ~act)
//  out_valid      out  1        one-cycle pulse: f/p/stored_data valid for the new block
// BEHAVIOUR
//  - Reset: state IDLE, blk_idx=0, in_ready=1, request=store_enable=0, read_write=0,
//    address=0, activation_in=0, index=0, f=p=0, stored_data=0, out_valid=0.
//  - Lane decision (in ANALYZE, registered): ok_d = ((act^sa_val)&sa_mask)==0;
//    ok_f = ((~act^sa_val)&sa_mask)==0. ok_d -> f=0,p=0,stored=act;
//    else ok_f -> f=1,p=0,stored=~act; else f=0,p=1,stored=act. Never f&p.
//  - FSM: IDLE -(in_valid)-> ANALYZE -> (any p ? WRITE : DONE); WRITE -> DONE after
//    last patched lane is accepted; DONE -> IDLE.
//  - in_ready = 1 only in IDLE; inputs captured at accept; ignored otherwise.
//  - WRITE: lanes with p=1 in ascending lane order, one per accepted write. request=
//    store_enable=1, index=lane, address={blk_idx,lane}, activation_in=act[lane];
//    all held stable while cache_ready=0. Lanes with p=0 are skipped (0 cycles).
//  - Latency (cache_ready=1): accept t; ANALYZE t+1; k writes t+2..t+1+k; DONE/out_valid
//    at t+2+k. f/p/stored_data update in DONE, hold until next DONE.
//  - blk_idx increments in DONE, wraps modulo 2^(ADDR_W-clog2(M)).
//  - k=M (all lanes patched) and k=0 both legal. Same-cycle in_valid in DONE is not
//    accepted (next cycle in IDLE). Back-to-back throughput: one block per 3+k cycles.
//  - Reset mid-WRITE: store_enable drops next cycle; partial block discarded, no out_valid.
// CONFIGURATION
//  PATCH_STATS_EN defined: adds outputs patch_count[15:0] and flip_count[15:0]; summed
//    in DONE by popcount(p)/popcount(f), saturating at 16'hFFFF; cleared by reset.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Package patch_pkg: state enum {IDLE, ANALYZE, WRITE, DONE}, lane_decision_t
//    {KEEP, FLIP, PATCH}, default N/M/ADDR_W constants.
//  - Sub-module patch_lane_classifier (combinational, one per lane): act, sa_mask,
//    sa_val -> lane_decision_t and stored word. Top holds FSM, lane scan, counters.
// TESTING
//  1 sa_mask=0 all lanes, act=16'h1234 -> f=0000,p=0000,no store_enable,out_valid at t+2.
//  2 lane0 mask=16'h0001 val=1, act=16'h0000 -> f[0]=1,p[0]=0,stored[0]=16'hFFFF.
//  3 lane2 mask=16'h0003 val=2'b01, act=16'h0000 -> p[2]=1, one write addr={blk,2},
//    data 16'h0000; out_valid at t+3.
//  4 all 4 lanes patched, cache_ready low 2 cycles on lane1 -> writes lanes 0..3 in order,
//    lane1 held stable while stalled, out_valid at t+8.
//  5 reset asserted during WRITE of lane1 -> store_enable=0 next cycle, no out_valid,
//    blk_idx=0, next block writes address {0,lane}.
//  6 PATCH_STATS_EN: 3 blocks with p=0011 and f=0100 -> patch_count=6, flip_count=3.

Source files
------------

// File: rtl/patch_pkg.sv
// -----------------------------------------------------------------------------
// patch_pkg
//   Shared types and default sizes for the patch encoder write path.
//   - state_t          : controller states of patch_encoder_writer
//   - lane_decision_t  : per-lane storage decision (keep / flip / patch)
//   - N_DEF, M_DEF, ADDR_W_DEF : default activation width, lanes per block,
//                                patch-cache address width
// -----------------------------------------------------------------------------
package patch_pkg;

  localparam int N_DEF      = 16;
  localparam int M_DEF      = 4;
  localparam int ADDR_W_DEF = 21;

  typedef enum logic [1:0] {
    IDLE,
    ANALYZE,
    WRITE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    KEEP,
    FLIP,
    PATCH
  } lane_decision_t;

endpackage

// File: rtl/patch_lane_classifier.sv
// -----------------------------------------------------------------------------
// patch_lane_classifier
//   Combinational decision for one lane: can the activation be stored as-is
//   over the stuck cells, stored inverted, or must it be patched.
//   Ports:
//     act      in  N   original activation
//     sa_mask  in  N   1 = stuck bit cell
//     sa_val   in  N   stuck value of each faulty cell
//     decision out     KEEP / FLIP / PATCH
//     stored   out N   word written to the faulty row (act or ~act)
// -----------------------------------------------------------------------------
module patch_lane_classifier
  import patch_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0]   act,
  input  logic [N-1:0]   sa_mask,
  input  logic [N-1:0]   sa_val,
  output lane_decision_t decision,
  output logic [N-1:0]   stored
);

  logic ok_d;
  logic ok_f;

  // A faulty cell is harmless when the bit we want to write equals its stuck value.
  assign ok_d = ((act ^ sa_val) & sa_mask) == '0;
  assign ok_f = ((~act ^ sa_val) & sa_mask) == '0;

  always_comb begin
    decision = PATCH;
    stored   = act;
    if (ok_d) begin
      decision = KEEP;
    end else if (ok_f) begin
      decision = FLIP;
      stored   = ~act;
    end
  end

endmodule

// File: rtl/patch_encoder_writer.sv
// -----------------------------------------------------------------------------
// patch_encoder_writer
//   Write-side encoder for the flip/patch memory scheme. Accepts a block of M
//   activations with the stuck-at map of the target row, classifies every lane,
//   streams patched lanes into the patch cache in ascending lane order, then
//   presents f/p flags and the words to store together with a one-cycle
//   out_valid pulse.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     in_valid / in_ready        block handshake (ready only while idle)
//     act_in, sa_mask, sa_val    N x M block inputs, lane i at [i*N +: N]
//     request, read_write        cache access request, always a write (0)
//     address                    {blk_idx, lane}
//     activation_in, index       patch word and its lane
//     store_enable, cache_ready  write strobe held until the cache accepts
//     f, p, stored_data          results of the last completed block
//     out_valid                  one-cycle pulse when results update
//     patch_count, flip_count    (PATCH_STATS_EN only) saturating totals
//   Build option: define PATCH_STATS_EN to add the statistics counters.
// -----------------------------------------------------------------------------
module patch_encoder_writer
  import patch_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int M      = M_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*M-1:0]        act_in,
  input  logic [N*M-1:0]        sa_mask,
  input  logic [N*M-1:0]        sa_val,
  output logic                  request,
  output logic                  read_write,
  output logic [ADDR_W-1:0]     address,
  output logic [N-1:0]          activation_in,
  output logic [$clog2(M)-1:0]  index,
  output logic                  store_enable,
  input  logic                  cache_ready,
  output logic [M-1:0]          f,
  output logic [M-1:0]          p,
  output logic [N*M-1:0]        stored_data,
`ifdef PATCH_STATS_EN
  output logic [15:0]           patch_count,
  output logic [15:0]           flip_count,
`endif
  output logic                  out_valid
);

  localparam int LW = $clog2(M);
  localparam int BW = ADDR_W - LW;

  state_t         state, state_nx;
  logic [N*M-1:0] act_r, mask_r, val_r;
  lane_decision_t dec [M];
  logic [N*M-1:0] stored_c;
  logic [M-1:0]   f_c, p_c;
  logic [M-1:0]   p_work;
  logic [LW-1:0]  cur_lane;
  logic [M-1:0]   cur_onehot;
  logic [BW-1:0]  blk_idx;
  logic           last_write;

`ifdef PATCH_STATS_EN
  function automatic logic [15:0] sat_add(input logic [15:0] acc, input logic [M-1:0] bits);
    logic [16:0] sum;
    sum = {1'b0, acc};
    for (int i = 0; i < M; i++) sum = sum + 17'(bits[i]);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction
`endif

  for (genvar g = 0; g < M; g++) begin : g_lane
    patch_lane_classifier #(.N(N)) u_cls (
      .act      (act_r[g*N +: N]),
      .sa_mask  (mask_r[g*N +: N]),
      .sa_val   (val_r[g*N +: N]),
      .decision (dec[g]),
      .stored   (stored_c[g*N +: N])
    );
    assign f_c[g] = (dec[g] == FLIP);
    assign p_c[g] = (dec[g] == PATCH);
  end

  // Lowest pending patched lane is the one currently on the cache port.
  always_comb begin
    cur_lane   = '0;
    cur_onehot = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (p_work[i]) cur_lane = LW'(i);
    end
    cur_onehot[cur_lane] = 1'b1;
  end

  assign last_write = (state == WRITE) && cache_ready && ((p_work & ~cur_onehot) == '0);

  always_comb begin
    state_nx      = state;
    in_ready      = (state == IDLE);
    store_enable  = (state == WRITE);
    request       = (state == WRITE);
    read_write    = 1'b0;
    out_valid     = (state == DONE);
    index         = '0;
    address       = '0;
    activation_in = '0;
    if (state == WRITE) begin
      index   = cur_lane;
      address = {blk_idx, cur_lane};
      for (int i = 0; i < M; i++) begin
        if (cur_lane == LW'(i)) activation_in = act_r[i*N +: N];
      end
    end
    case (state)
      IDLE:    if (in_valid) state_nx = ANALYZE;
      ANALYZE: state_nx = (|p_c) ? WRITE : DONE;
      WRITE:   if (last_write) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Block capture: the classifier inputs stay frozen until the next accept,
  // so the decisions are still valid on every path into DONE.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      act_r  <= act_in;
      mask_r <= sa_mask;
      val_r  <= sa_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      blk_idx     <= '0;
      p_work      <= '0;
      f           <= '0;
      p           <= '0;
      stored_data <= '0;
`ifdef PATCH_STATS_EN
      patch_count <= '0;
      flip_count  <= '0;
`endif
    end else begin
      state <= state_nx;
      if (state == ANALYZE) p_work <= p_c;
      if (state == WRITE && cache_ready) p_work[cur_lane] <= 1'b0;
      if (state != DONE && state_nx == DONE) begin
        f           <= f_c;
        p           <= p_c;
        stored_data <= stored_c;
      end
      if (state == DONE) begin
        blk_idx <= blk_idx + BW'(1);
`ifdef PATCH_STATS_EN
        patch_count <= sat_add(patch_count, p);
        flip_count  <= sat_add(flip_count, f);
`endif
      end
    end
  end

endmodule

// File: tb/tb_patch_encoder_writer.sv
// -----------------------------------------------------------------------------
// tb_patch_encoder_writer
//   Self-checking bench for patch_encoder_writer. Directed scenarios plus
//   randomized blocks with random cache back-pressure, compared against a
//   bit-level reference model of the keep/flip/patch rule.
//   Define PATCH_STATS_EN to also exercise the statistics counters.
// -----------------------------------------------------------------------------
module tb_patch_encoder_writer;

  localparam int N  = 16;
  localparam int M  = 4;
  localparam int AW = 21;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [N*M-1:0]  act_in, sa_mask, sa_val;
  logic            request, read_write, store_enable, cache_ready, out_valid;
  logic [AW-1:0]   address;
  logic [N-1:0]    activation_in;
  logic [1:0]      index;
  logic [M-1:0]    f, p;
  logic [N*M-1:0]  stored_data;
`ifdef PATCH_STATS_EN
  logic [15:0]     patch_count, flip_count;
`endif

  patch_encoder_writer #(.N(N), .M(M), .ADDR_W(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .act_in        (act_in),
    .sa_mask       (sa_mask),
    .sa_val        (sa_val),
    .request       (request),
    .read_write    (read_write),
    .address       (address),
    .activation_in (activation_in),
    .index         (index),
    .store_enable  (store_enable),
    .cache_ready   (cache_ready),
    .f             (f),
    .p             (p),
    .stored_data   (stored_data),
`ifdef PATCH_STATS_EN
    .patch_count   (patch_count),
    .flip_count    (flip_count),
`endif
    .out_valid     (out_valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_blk  = 0;

  // Observations gathered by run_block
  int              lat;
  int              nstall;
  int              unstable;
  int              proto_err;
  logic [M-1:0]    obs_f, obs_p;
  logic [N*M-1:0]  obs_stored;
  int              wr_idx[$];
  int              wr_addr[$];
  logic [N-1:0]    wr_data[$];

  // Reference: a lane keeps its word if every stuck cell already holds the
  // wanted bit, flips if every stuck cell holds the inverted bit, else patches.
  function automatic void model_block(input logic [N*M-1:0] a, mk, v,
                                      output logic [M-1:0] fe, pe,
                                      output logic [N*M-1:0] se);
    fe = '0; pe = '0; se = '0;
    for (int l = 0; l < M; l++) begin
      bit plain_ok = 1;
      bit inv_ok   = 1;
      for (int b = 0; b < N; b++) begin
        if (mk[l*N+b]) begin
          if (v[l*N+b] != a[l*N+b])  plain_ok = 0;
          if (v[l*N+b] == a[l*N+b])  inv_ok   = 0;
        end
      end
      if (plain_ok)    se[l*N +: N] = a[l*N +: N];
      else if (inv_ok) begin fe[l] = 1'b1; se[l*N +: N] = ~a[l*N +: N]; end
      else             begin pe[l] = 1'b1; se[l*N +: N] = a[l*N +: N]; end
    end
  endfunction

  function automatic int exp_addr(input int blk, input int lane);
    return (blk * M + lane) % (1 << AW);
  endfunction

  // Offers one block from IDLE and records what the DUT does until out_valid.
  task automatic run_block(input logic [N*M-1:0] a, mk, v,
                           input int stall_lane, input int stall_n, input bit rnd);
    int stalls = stall_n;
    bit prev_stall = 0;
    logic [1:0] pidx = '0;
    logic [AW-1:0] paddr = '0;
    logic [N-1:0] pdata = '0;
    wr_idx.delete(); wr_addr.delete(); wr_data.delete();
    lat = -1; nstall = 0; unstable = 0; proto_err = 0;
    @(negedge clk);
    in_valid = 1'b1; act_in = a; sa_mask = mk; sa_val = v; cache_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    act_in = {$urandom, $urandom}; sa_mask = {$urandom, $urandom}; sa_val = {$urandom, $urandom};
    for (int n = 1; n < 80; n++) begin
      if (request !== store_enable || read_write !== 1'b0) proto_err++;
      if (prev_stall && (store_enable !== 1'b1 || index !== pidx ||
                         address !== paddr || activation_in !== pdata)) unstable++;
      if (out_valid === 1'b1) begin
        lat = n; obs_f = f; obs_p = p; obs_stored = stored_data;
        break;
      end
      if (store_enable === 1'b1) begin
        if (rnd) cache_ready = 1'($urandom_range(0, 1));
        else if (int'(index) == stall_lane && stalls > 0) begin cache_ready = 1'b0; stalls--; end
        else cache_ready = 1'b1;
        prev_stall = !cache_ready;
        pidx = index; paddr = address; pdata = activation_in;
        if (cache_ready) begin
          wr_idx.push_back(int'(index)); wr_addr.push_back(int'(address)); wr_data.push_back(activation_in);
        end else nstall++;
      end else begin
        cache_ready = 1'b1;
        prev_stall = 0;
      end
      @(negedge clk);
    end
    cache_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; cache_ready = 1'b1;
    act_in = '0; sa_mask = '0; sa_val = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || request !== 1'b0 || store_enable !== 1'b0 || read_write !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got in_ready=%b request=%b store_enable=%b rw=%b exp 1 0 0 0",
               in_ready, request, store_enable, read_write);
    end
    checks++;
    if (address !== '0 || activation_in !== '0 || index !== '0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_port got addr=%h act=%h idx=%0d ov=%b exp zeros", address, activation_in, index, out_valid);
    end
    checks++;
    if (f !== '0 || p !== '0 || stored_data !== '0) begin
      failures++;
      $display("FAIL reset_result got f=%b p=%b stored=%h exp zeros", f, p, stored_data);
    end
    reset = 1'b0;
    exp_blk = 0;
  endtask

  task automatic test_no_fault();
    logic [N*M-1:0] a = {M{16'h1234}};
    run_block(a, '0, {$urandom, $urandom}, -1, 0, 0);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL t1_latency got=%0d exp=2", lat); end
    checks++;
    if (obs_f !== 4'b0000 || obs_p !== 4'b0000) begin
      failures++; $display("FAIL t1_fp got f=%b p=%b exp f=0000 p=0000", obs_f, obs_p);
    end
    checks++;
    if (wr_idx.size() !== 0 || obs_stored !== a) begin
      failures++; $display("FAIL t1_store got writes=%0d stored=%h exp 0 %h", wr_idx.size(), obs_stored, a);
    end
    exp_blk++;
  endtask

  task automatic test_flip();
    run_block('0, 64'h1, 64'h1, -1, 0, 0);
    checks++;
    if (obs_f !== 4'b0001 || obs_p !== 4'b0000) begin
      failures++; $display("FAIL t2_fp got f=%b p=%b exp f=0001 p=0000", obs_f, obs_p);
    end
    checks++;
    if (obs_stored !== 64'h0000_0000_0000_FFFF) begin
      failures++; $display("FAIL t2_stored got=%h exp=%h", obs_stored, 64'h0000_0000_0000_FFFF);
    end
    exp_blk++;
    repeat (3) @(negedge clk);
    checks++;
    if (f !== 4'b0001 || stored_data !== 64'h0000_0000_0000_FFFF || out_valid !== 1'b0) begin
      failures++; $display("FAIL t2_hold got f=%b stored=%h ov=%b exp 0001 %h 0", f, stored_data, out_valid, 64'hFFFF);
    end
  endtask

  task automatic test_single_patch();
    run_block('0, 64'h0003_0000_0000, 64'h0001_0000_0000, -1, 0, 0);
    checks++;
    if (obs_p !== 4'b0100 || obs_f !== 4'b0000) begin
      failures++; $display("FAIL t3_fp got f=%b p=%b exp f=0000 p=0100", obs_f, obs_p);
    end
    checks++;
    if (wr_idx.size() !== 1) begin
      failures++; $display("FAIL t3_count got=%0d exp=1", wr_idx.size());
    end else if (wr_addr[0] !== exp_addr(exp_blk, 2) || wr_data[0] !== 16'h0000 || wr_idx[0] !== 2) begin
      failures++; $display("FAIL t3_write got addr=%0d idx=%0d data=%h exp addr=%0d idx=2 data=0000",
                           wr_addr[0], wr_idx[0], wr_data[0], exp_addr(exp_blk, 2));
    end
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL t3_latency got=%0d exp=3", lat); end
    exp_blk++;
  endtask

  task automatic test_all_patch_stall();
    logic [N*M-1:0] a = {$urandom, $urandom} & ~{M{16'h0003}};
    run_block(a, {M{16'h0003}}, {M{16'h0001}}, 1, 2, 0);
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL t4_latency got=%0d exp=8", lat); end
    checks++;
    if (obs_p !== 4'b1111 || unstable !== 0) begin
      failures++; $display("FAIL t4_p_stable got p=%b unstable=%0d exp 1111 0", obs_p, unstable);
    end
    checks++;
    if (wr_idx.size() !== 4) begin
      failures++; $display("FAIL t4_count got=%0d exp=4", wr_idx.size());
    end else begin
      for (int l = 0; l < M; l++) begin
        checks++;
        if (wr_idx[l] !== l || wr_addr[l] !== exp_addr(exp_blk, l) || wr_data[l] !== a[l*N +: N]) begin
          failures++; $display("FAIL t4_write%0d got idx=%0d addr=%0d data=%h exp idx=%0d addr=%0d data=%h",
                               l, wr_idx[l], wr_addr[l], wr_data[l], l, exp_addr(exp_blk, l), a[l*N +: N]);
        end
      end
    end
    exp_blk++;
  endtask

  task automatic test_reset_mid_write();
    bit found = 0;
    int ov = 0;
    @(negedge clk);
    in_valid = 1'b1; act_in = '0; sa_mask = {M{16'h0003}}; sa_val = {M{16'h0001}}; cache_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (store_enable === 1'b1 && index === 2'd1) begin found = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!found) begin failures++; $display("FAIL t5_reach_lane1 got=0 exp=1"); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (store_enable !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL t5_drop got store_enable=%b out_valid=%b exp 0 0", store_enable, out_valid);
    end
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) ov++;
    end
    checks++;
    if (ov !== 0) begin failures++; $display("FAIL t5_no_out got=%0d exp=0", ov); end
    exp_blk = 0;
    run_block('0, 64'h0000_0000_0003_0000, 64'h0000_0000_0001_0000, -1, 0, 0);
    checks++;
    if (wr_idx.size() !== 1 || wr_addr[0] !== exp_addr(0, 1)) begin
      failures++; $display("FAIL t5_addr got writes=%0d addr=%0d exp 1 %0d",
                           wr_idx.size(), (wr_addr.size() > 0) ? wr_addr[0] : -1, exp_addr(0, 1));
    end
    exp_blk++;
  endtask

  task automatic test_random();
    logic [M-1:0]   fe, pe;
    logic [N*M-1:0] se, a, mk, v;
    int k, w;
    for (int b = 0; b < 25; b++) begin
      a  = {$urandom, $urandom};
      mk = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      v  = {$urandom, $urandom};
      model_block(a, mk, v, fe, pe, se);
      run_block(a, mk, v, -1, 0, 1);
      k = $countones(pe);
      checks++;
      if (lat !== 2 + k + nstall) begin
        failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", b, lat, 2 + k + nstall);
      end
      checks++;
      if (obs_f !== fe || obs_p !== pe || obs_stored !== se || (obs_f & obs_p) !== '0) begin
        failures++; $display("FAIL rnd%0d_result got f=%b p=%b st=%h exp f=%b p=%b st=%h",
                             b, obs_f, obs_p, obs_stored, fe, pe, se);
      end
      checks++;
      if (wr_idx.size() !== k || unstable !== 0 || proto_err !== 0) begin
        failures++; $display("FAIL rnd%0d_port got writes=%0d unstable=%0d proto=%0d exp %0d 0 0",
                             b, wr_idx.size(), unstable, proto_err, k);
      end
      w = 0;
      for (int l = 0; l < M; l++) begin
        if (pe[l] && w < wr_idx.size()) begin
          checks++;
          if (wr_idx[w] !== l || wr_addr[w] !== exp_addr(exp_blk, l) || wr_data[w] !== a[l*N +: N]) begin
            failures++; $display("FAIL rnd%0d_write got idx=%0d addr=%0d data=%h exp idx=%0d addr=%0d data=%h",
                                 b, wr_idx[w], wr_addr[w], wr_data[w], l, exp_addr(exp_blk, l), a[l*N +: N]);
          end
          w++;
        end
      end
      exp_blk++;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL rnd%0d_pulse got=%b exp=0", b, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    int prev = -1;
    int pulses = 0;
    @(negedge clk);
    in_valid = 1'b1; act_in = '0; sa_mask = 64'h0003_0000_0000_0000; sa_val = 64'h0001_0000_0000_0000;
    cache_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (prev >= 0) begin
          checks++;
          if (c - prev !== 4) begin failures++; $display("FAIL b2b_spacing got=%0d exp=4", c - prev); end
        end
        prev = c;
        pulses++;
      end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses < 9 || p !== 4'b1000) begin
      failures++; $display("FAIL b2b_blocks got pulses=%0d p=%b exp >=9 1000", pulses, p);
    end
    exp_blk += pulses;
    run_block('0, 64'h0003, 64'h0001, -1, 0, 0);
    checks++;
    if (wr_addr.size() !== 1 || wr_addr[0] !== exp_addr(exp_blk, 0)) begin
      failures++; $display("FAIL b2b_blk_idx got addr=%0d exp=%0d",
                           (wr_addr.size() > 0) ? wr_addr[0] : -1, exp_addr(exp_blk, 0));
    end
    exp_blk++;
  endtask

`ifdef PATCH_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_blk = 0;
    checks++;
    if (patch_count !== 16'd0 || flip_count !== 16'd0) begin
      failures++; $display("FAIL stats_reset got pc=%0d fc=%0d exp 0 0", patch_count, flip_count);
    end
    for (int b = 0; b < 3; b++) begin
      run_block('0, 64'h0000_0001_0003_0003, 64'h0000_0001_0001_0001, -1, 0, 0);
      exp_blk++;
    end
    @(negedge clk);
    checks++;
    if (patch_count !== 16'd6 || flip_count !== 16'd3) begin
      failures++; $display("FAIL stats_count got pc=%0d fc=%0d exp 6 3", patch_count, flip_count);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_no_fault();
    test_flip();
    test_single_patch();
    test_all_patch_stall();
    test_reset_mid_write();
    test_random();
    test_back_to_back();
`ifdef PATCH_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
